// File: rtl/laser_shot_scheduler.sv
// Laser shot scheduler: drives the pulse generator for one burst, counts detected shots,
// requires a receiver acknowledge per shot and ends the burst on completion, abort, overrun or timeout.
module laser_shot_scheduler #(
  parameter int SHOT_W        = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int TIMEOUT_W     = 20,
  parameter int TIMEOUT       = 200000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START,
  input  logic              ABORT,
  input  logic [1:0]        CFG_MODE,
  input  logic [SHOT_W-1:0] CFG_SHOTS,
  input  logic              PULSE_SYNC,
  input  logic              RX_DONE,
  output logic              LP_EN,
  output logic [1:0]        LP_MODE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_OVERRUN,
  output logic              ERR_TIMEOUT,
  output logic [SHOT_W-1:0] SHOTS_FIRED,
  output logic [2:0]        DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ARM     = 3'd2,
    S_WAIT_RX = 3'd3,
    S_FINISH  = 3'd4
  } state_e;

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  state_e            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [SHOT_W-1:0] shots_q, shots_d;
  logic [SHOT_W-1:0] fired_q, fired_d;
  logic [1:0]        mode_q, mode_d;
  logic              ovr_q, ovr_d;
  logic              tmo_q, tmo_d;
  logic              pulse_q;
  logic              en_q, busy_q, done_q;
  logic              rise, wd_exp, last_shot;

  assign rise      = PULSE_SYNC & ~pulse_q;
  assign wd_exp    = (wd_q == TIMEOUT_W'(TIMEOUT - 1));
  assign last_shot = (fired_q == shots_q);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    wd_d     = wd_q;
    shots_d  = shots_q;
    fired_d  = fired_q;
    mode_d   = mode_q;
    ovr_d    = ovr_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          ovr_d   = 1'b0;
          tmo_d   = 1'b0;
          fired_d = '0;
          if (CFG_SHOTS != '0) begin
            shots_d  = CFG_SHOTS;
            mode_d   = CFG_MODE;
            settle_d = '0;
            state_d  = S_SETUP;
          end else begin
            state_d  = S_FINISH;
          end
        end
      end
      S_SETUP: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          wd_d    = '0;
          state_d = S_ARM;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_ARM: begin
        // RX_DONE here has no shot to acknowledge and is dropped
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (rise) begin
          fired_d = fired_q + 1'b1;
          wd_d    = '0;
          state_d = S_WAIT_RX;
        end else if (wd_exp) begin
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WAIT_RX: begin
        if (ABORT) begin
          state_d = S_IDLE;
        end else if (RX_DONE && rise) begin
          // acknowledge closes this shot; the rise is the next one unless the burst is complete
          wd_d = '0;
          if (last_shot) begin
            ovr_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            fired_d = fired_q + 1'b1;
          end
        end else if (RX_DONE) begin
          wd_d    = '0;
          state_d = last_shot ? S_FINISH : S_ARM;
        end else if (rise) begin
          ovr_d   = 1'b1;
          if (!last_shot) fired_d = fired_q + 1'b1;
          state_d = S_FINISH;
        end else if (wd_exp) begin
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      wd_q     <= '0;
      shots_q  <= '0;
      fired_q  <= '0;
      mode_q   <= 2'd0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      pulse_q  <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      wd_q     <= wd_d;
      shots_q  <= shots_d;
      fired_q  <= fired_d;
      mode_q   <= mode_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
      pulse_q  <= PULSE_SYNC;
      // enable and busy follow the state being entered; DONE follows the FINISH cycle
      en_q     <= (state_d == S_ARM) || (state_d == S_WAIT_RX);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_q == S_FINISH);
    end
  end

  assign LP_EN       = en_q;
  assign LP_MODE     = mode_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERR_OVERRUN = ovr_q;
  assign ERR_TIMEOUT = tmo_q;
  assign SHOTS_FIRED = fired_q;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_laser_shot_scheduler.sv
// Bench for laser_shot_scheduler: directed and random bursts scored against a shot-level model.
module tb_laser_shot_scheduler;

  localparam int SHOT_W = 16;
  localparam int SETTLE = 8;
  localparam int TOUT   = 100;
  localparam int NMAX   = 1400;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0, abort = 1'b0, pulse = 1'b0, rx = 1'b0;
  logic [1:0]        cfg_mode = 2'd0;
  logic [SHOT_W-1:0] cfg_shots = '0;
  logic              lp_en, busy, done, err_ovr, err_tmo;
  logic [1:0]        lp_mode;
  logic [SHOT_W-1:0] shots_fired;
  logic [2:0]        dbg_state;

  laser_shot_scheduler #(
    .SHOT_W(SHOT_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_W(20), .TIMEOUT(TOUT)
  ) dut (
    .CLK(clk), .RSTn(rstn), .START(start), .ABORT(abort),
    .CFG_MODE(cfg_mode), .CFG_SHOTS(cfg_shots),
    .PULSE_SYNC(pulse), .RX_DONE(rx),
    .LP_EN(lp_en), .LP_MODE(lp_mode), .BUSY(busy), .DONE(done),
    .ERR_OVERRUN(err_ovr), .ERR_TIMEOUT(err_tmo),
    .SHOTS_FIRED(shots_fired), .DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int bid      = 0;
  int cur_mode = 0;

  bit p_v[NMAX];
  bit r_v[NMAX];
  bit a_v[NMAX];
  bit sb_v[NMAX];
  int o_en[NMAX+1], o_busy[NMAX+1], o_done[NMAX+1], o_sf[NMAX+1];
  int o_ovr[NMAX+1], o_tmo[NMAX+1], o_mode[NMAX+1];

  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      p_v[i] = 1'b0; r_v[i] = 1'b0; a_v[i] = 1'b0; sb_v[i] = 1'b0;
    end
  endtask

  // Shot-level reference: walks the stimulus timeline tracking whether a shot awaits its
  // acknowledge, then pushes the expected burst summary into exp_q.
  task automatic model(input int shots, input int len);
    int  sf, t, base;
    bit  ovr, tmo, aborted, waiting, ended, rise;
    sf = 0; t = len; ovr = 0; tmo = 0; aborted = 0; waiting = 0; ended = 0;
    if (shots == 0) begin
      t = 0; ended = 1;
    end
    for (int c = 1; c <= SETTLE && !ended; c++) begin
      if (a_v[c]) begin t = c; aborted = 1; ended = 1; end
    end
    base = SETTLE + 1;
    for (int c = SETTLE + 1; c < len && !ended; c++) begin
      rise = p_v[c] && !p_v[c-1];
      if (a_v[c]) begin
        aborted = 1; t = c; ended = 1;
      end else if (!waiting) begin
        if (rise) begin sf++; waiting = 1; base = c + 1; end
        else if (c - base == TOUT - 1) begin tmo = 1; t = c; ended = 1; end
      end else if (r_v[c] && sf == shots) begin
        if (rise) ovr = 1;
        t = c; ended = 1;
      end else if (r_v[c] && rise) begin
        sf++; base = c + 1;
      end else if (r_v[c]) begin
        waiting = 0; base = c + 1;
      end else if (rise) begin
        ovr = 1;
        if (sf < shots) sf++;
        t = c; ended = 1;
      end else if (c - base == TOUT - 1) begin
        tmo = 1; t = c; ended = 1;
      end
    end
    if (shots != 0) begin
      exp_q.push_back((t > SETTLE) ? SETTLE + 1 : -1);
      exp_q.push_back((t > SETTLE) ? t - SETTLE : 0);
    end else begin
      exp_q.push_back(-1);
      exp_q.push_back(0);
    end
    exp_q.push_back(aborted ? 0 : 1);
    exp_q.push_back(aborted ? -1 : t + 2);
    exp_q.push_back(aborted ? t + 1 : t + 2);
    exp_q.push_back(sf);
    exp_q.push_back(sf);
    exp_q.push_back(ovr);
    exp_q.push_back(tmo);
    exp_q.push_back(cur_mode);
  endtask

  task automatic run_burst(input int shots, input int mode, input int len);
    logic [1:0] m2;
    int en_first, en_cnt, d_cnt, d_idx, b_fall, steps;
    m2 = mode[1:0];
    if (shots != 0) cur_mode = mode;
    model(shots, len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      start     = (c == 0) || sb_v[c];
      cfg_mode  = (c == 0) ? m2 : (sb_v[c] ? ~m2 : 2'($urandom_range(0, 3)));
      cfg_shots = (c == 0) ? SHOT_W'(shots) : SHOT_W'(shots + 2);
      pulse     = p_v[c];
      rx        = r_v[c];
      abort     = a_v[c];
      @(posedge clk); #1;
      o_en[c+1] = int'(lp_en);   o_busy[c+1] = int'(busy); o_done[c+1] = int'(done);
      o_sf[c+1] = int'(shots_fired); o_ovr[c+1] = int'(err_ovr);
      o_tmo[c+1] = int'(err_tmo); o_mode[c+1] = int'(lp_mode);
    end
    @(negedge clk);
    start = 0; pulse = 0; rx = 0; abort = 0;
    en_first = -1; en_cnt = 0; d_cnt = 0; d_idx = -1; b_fall = -1; steps = 0;
    for (int i = 1; i <= len; i++) begin
      if (o_en[i] == 1) begin en_cnt++; if (en_first < 0) en_first = i; end
      if (o_done[i] == 1) begin d_cnt++; if (d_idx < 0) d_idx = i; end
      if (o_busy[i] == 0 && b_fall < 0) b_fall = i;
      if (i >= 2 && o_sf[i] == o_sf[i-1] + 1) steps++;
    end
    check_eq($sformatf("b%0d_en_first", bid),  en_first,     int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_en_cycles", bid), en_cnt,       int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_done_cnt", bid),  d_cnt,        int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_done_idx", bid),  d_idx,        int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_busy_fall", bid), b_fall,       int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_shots", bid),     o_sf[len],    int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_sf_steps", bid),  steps,        int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_overrun", bid),   o_ovr[len],   int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_timeout", bid),   o_tmo[len],   int'(exp_q.pop_front()));
    check_eq($sformatf("b%0d_mode", bid),      o_mode[len],  int'(exp_q.pop_front()));
    bid++;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_lp_en"}, int'(lp_en), 0);
    check_eq({pfx, "_lp_mode"}, int'(lp_mode), 0);
    check_eq({pfx, "_busy"}, int'(busy), 0);
    check_eq({pfx, "_done"}, int'(done), 0);
    check_eq({pfx, "_ovr"}, int'(err_ovr), 0);
    check_eq({pfx, "_tmo"}, int'(err_tmo), 0);
    check_eq({pfx, "_sf"}, int'(shots_fired), 0);
  endtask

  task automatic gen_random(output int shots, output int mode, output int len);
    int cur, w, rxc, sel, stim_end;
    clear_stim();
    shots = $urandom_range(0, 5);
    mode  = $urandom_range(0, 3);
    cur   = $urandom_range(10, 16);
    stim_end = cur;
    for (int k = 0; k < shots + 1 && cur < 1000; k++) begin
      w = $urandom_range(1, 3);
      if ($urandom_range(0, 5) == 0) r_v[cur-1] = 1'b1;
      for (int j = 0; j < w; j++) p_v[cur+j] = 1'b1;
      stim_end = cur + w;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        cur = cur + w + $urandom_range(1, 20);
      end else begin
        rxc = cur + $urandom_range(1, 60);
        r_v[rxc] = 1'b1;
        if (rxc > stim_end) stim_end = rxc;
        cur = (sel == 1) ? rxc : rxc + $urandom_range(1, 110);
      end
    end
    if (shots != 0 && $urandom_range(0, 7) == 0) a_v[$urandom_range(4, stim_end)] = 1'b1;
    if (shots != 0) sb_v[3] = 1'b1;
    len = stim_end + 120;
  endtask

  initial begin
    int shots, mode, len, b_cnt, e_cnt;
    clear_stim();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    // three shots, acknowledge 50 cycles after each pulse
    clear_stim();
    p_v[12] = 1; r_v[62] = 1; p_v[70] = 1; p_v[71] = 1; r_v[120] = 1;
    p_v[130] = 1; r_v[180] = 1;
    run_burst(3, 2, 200);

    // zero-shot burst
    clear_stim();
    run_burst(0, 1, 10);

    // acknowledge withheld after shot 2
    clear_stim();
    p_v[12] = 1; r_v[20] = 1; p_v[30] = 1; p_v[50] = 1;
    run_burst(4, 3, 80);

    // no pulses: watchdog expires
    clear_stim();
    run_burst(2, 1, 130);

    // abort with coincident acknowledge, after a START while busy
    clear_stim();
    sb_v[3] = 1; p_v[12] = 1; a_v[20] = 1; r_v[20] = 1;
    run_burst(2, 1, 40);

    // START together with ABORT in IDLE is dropped
    @(negedge clk);
    start = 1; abort = 1; cfg_mode = 2'd3; cfg_shots = SHOT_W'(3);
    b_cnt = 0; e_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy) b_cnt++;
      if (lp_en) e_cnt++;
      @(negedge clk);
      start = 0; abort = 0;
    end
    check_eq("start_abort_busy", b_cnt, 0);
    check_eq("start_abort_en", e_cnt, 0);

    // asynchronous reset while armed
    @(negedge clk);
    start = 1; cfg_mode = 2'd3; cfg_shots = SHOT_W'(5);
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    check_eq("pre_rst_en", int'(lp_en), 1);
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    cur_mode = 0;
    clear_stim();
    p_v[15] = 1; r_v[30] = 1; p_v[40] = 1; p_v[41] = 1; r_v[45] = 1;
    run_burst(2, 2, 80);

    for (int n = 0; n < 25; n++) begin
      gen_random(shots, mode, len);
      run_burst(shots, mode, len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
